// File: rtl/program_counter_core_if.sv
// Fetch-path bus for the program counter: next-address load request in,
// current and sequential-next address out.
interface program_counter_core_if #(
  parameter int D = 12
);
  logic         enable;
  logic [D-1:0] pc_in;
  logic [D-1:0] pc_out;
  logic [D-1:0] pc_added;

  // Drives the load request (next-PC mux / fetch control side).
  modport master (
    output enable,
    output pc_in,
    input  pc_out,
    input  pc_added
  );

  // The program counter itself.
  modport slave (
    input  enable,
    input  pc_in,
    output pc_out,
    output pc_added
  );
endinterface

// File: rtl/program_counter_core.sv
// Program counter: a single D-bit register loaded from pc_in when enabled,
// with a combinational sequential-next address (pc + 1, wrapping).
module program_counter_core #(
  parameter int           D         = 12,
  parameter logic [D-1:0] RESET_VAL = '0
) (
  input  logic                     clock,
  input  logic                     reset,   // asynchronous, active-low
  program_counter_core_if.slave    bus
);

  localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

  logic [D-1:0] pc_reg_q;
  logic [D-1:0] pc_reg_d;

  // Next-state select: load on enable, otherwise hold. An unknown enable
  // falls through the if to the hold branch, so X never reaches the register.
  always_comb begin
    pc_reg_d = pc_reg_q;
    if (bus.enable) begin
      pc_reg_d = bus.pc_in;
    end
  end

  // PC register; reset forces RESET_VAL immediately and overrides any load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg_q <= RESET_VAL;
    end else begin
      pc_reg_q <= pc_reg_d;
    end
  end

  assign bus.pc_out   = pc_reg_q;
  assign bus.pc_added = pc_reg_q + ONE;

endmodule

// File: tb/tb_program_counter_core.sv
// Self-checking bench for program_counter_core: directed scenarios followed by
// randomized loads, holds and asynchronous resets against a simple model.
module tb_program_counter_core;

  localparam int D    = 12;
  localparam int MASK = (1 << D) - 1;

  logic clock = 1'b0;
  logic reset;

  program_counter_core_if #(.D(D)) bus ();

  program_counter_core #(.D(D), .RESET_VAL('0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pc   = 0;   // reference model: the value the PC should hold

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare both outputs against the model.
  task automatic check_outputs(input string tag);
    check_val({tag, "_pc_out"},   int'(bus.pc_out),   exp_pc);
    check_val({tag, "_pc_added"}, int'(bus.pc_added), (exp_pc + 1) & MASK);
  endtask

  // One rising edge: update the model from the inputs presented at the edge,
  // then sample the DUT 1 ns later.
  task automatic step(input string tag);
    int in_v;
    bit en_v;
    in_v = int'(bus.pc_in);
    en_v = (bus.enable === 1'b1);
    @(posedge clock);
    if (reset !== 1'b1)  exp_pc = 0;
    else if (en_v)       exp_pc = in_v;
    #1;
    check_outputs(tag);
  endtask

  // Pull reset low between edges and confirm the PC drops at once.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    exp_pc = 0;
    #1;
    check_outputs(tag);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    bus.enable = 1'b1;
    bus.pc_in  = 12'h055;
    #2;
    check_outputs("reset_init");

    // Reset held low: clock and enable ignored.
    for (int i = 0; i < 3; i++) step("reset_hold");

    // Release between edges; count by feeding pc_added back.
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.enable = 1'b1;
      bus.pc_in  = bus.pc_added;
      step("incr");
      check_val("incr_count", int'(bus.pc_out), i + 1);
    end

    // Constant jump to 3.
    bus.pc_in = 12'd3;
    for (int i = 0; i < 10; i++) begin
      step("jump");
      check_val("jump_const", int'(bus.pc_out), 3);
    end

    // Hold at 7 with enable low, then load 0x123.
    bus.pc_in = 12'd7;
    step("load7");
    bus.enable = 1'b0;
    bus.pc_in  = 12'h123;
    for (int i = 0; i < 5; i++) begin
      step("hold");
      check_val("hold_val", int'(bus.pc_out), 7);
    end
    bus.enable = 1'b1;
    step("hold_release");
    check_val("hold_load", int'(bus.pc_out), 12'h123);

    // Wrap-around at all-ones.
    bus.pc_in = 12'hFFF;
    step("wrap_load");
    check_val("wrap_added", int'(bus.pc_added), 0);
    bus.pc_in = bus.pc_added;
    step("wrap_next");
    check_val("wrap_out", int'(bus.pc_out), 0);

    // Count to 5, reset mid-cycle, then resume counting from 0.
    for (int i = 0; i < 5; i++) begin
      bus.pc_in = bus.pc_added;
      step("pre_rst");
    end
    check_val("pre_rst_val", int'(bus.pc_out), 5);
    async_reset("mid_rst");
    check_val("mid_rst_val", int'(bus.pc_out), 0);
    for (int i = 0; i < 3; i++) begin
      bus.pc_in = bus.pc_added;
      step("post_rst");
      check_val("post_rst_count", int'(bus.pc_out), i + 1);
    end

    // Randomized mix of loads, holds, increments and async resets.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       async_reset("rnd_rst");
        1, 2:    begin bus.enable = 1'b1; bus.pc_in = bus.pc_added; end
        3, 4, 5: begin bus.enable = 1'b1; bus.pc_in = D'($urandom); end
        default: begin bus.enable = 1'b0; bus.pc_in = D'($urandom); end
      endcase
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter_core.md
Name: program_counter_core

Overview:
- Holds the processor's current instruction address.
- Combinationally provides the sequential next address (current + 1).
- On each rising clock edge, loads an externally selected next address when enabled.
- Sits at the front of the fetch path: pc_out drives instruction memory; pc_added feeds the next-PC mux, which returns its result on pc_in.

Parameters:
- D, 12, address width in bits; all address ports are D bits wide.
- RESET_VAL, 0, value loaded into the PC on reset; must fit in D bits.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  active-high load enable for the PC register.
- pc_in  input  D  next-address value to load.
- pc_out  output  D  current PC value, registered.
- pc_added  output  D  pc_out + 1, modulo 2^D, combinational.

Behaviour:
- Single D-bit state register, pc_reg; pc_out = pc_reg directly, with no extra output stage.
- Reset:
  - reset low forces pc_reg = RESET_VAL immediately, independent of clock.
  - pc_reg holds RESET_VAL while reset stays low; clock and enable are ignored.
  - Reset asserted mid-operation overrides any pending load immediately.
- Release: after reset deasserts, the first rising clock edge with enable=1 loads pc_in. Release coincident with a clock edge does not load on that edge.
- Rising clock edge, reset high, enable=1: pc_reg <= pc_in. One-cycle latency from pc_in to pc_out.
- Rising clock edge, reset high, enable=0: pc_reg holds its value.
- enable X or Z: treated as no load; pc_reg holds. Simulation must not propagate X into pc_reg.
- pc_added:
  - Purely combinational: pc_reg + 1, truncated to D bits.
  - Wrap-around: all-ones + 1 = 0, with no carry out.
  - Tracks pc_out within the same cycle, so it is RESET_VAL + 1 during reset.
- Feedback loop pc_in = pc_added with enable=1 gives an incrementing count: one step per clock edge, no combinational loop, because the path passes through pc_reg.
- A constant pc_in with enable=1 makes pc_out settle to that constant after one edge and stay there.
- No other outputs and no internal state beyond pc_reg.

Test Plan:
- Reset: hold reset low with clock toggling and enable=1, pc_in=0x055 -> pc_out=0x000 and pc_added=0x001 throughout; assert reset asynchronously between edges -> pc_out drops to 0 immediately.
- Increment loop: release reset, enable=1, drive pc_in=pc_added before each edge, run 10 edges -> pc_out reads 1,2,…,10 after successive edges; pc_added = pc_out+1 at each.
- Constant jump: with pc_out=10, set pc_in=3 with enable=1 for 10 edges -> pc_out=3 after the first edge and remains 3; pc_added=4.
- Hold: pc_out=7, enable=0, pc_in=0x123, 5 edges -> pc_out stays 7; set enable=1 -> next edge pc_out=0x123.
- Wrap: load pc_in=0xFFF (D=12) -> pc_added=0x000; feed pc_added back -> pc_out=0x000 after next edge.
- Reset mid-run: counting at pc_out=5, pull reset low between edges -> pc_out=RESET_VAL at once; release, continue counting -> 1,2,3 from RESET_VAL=0.
